// File: rtl/button_router_n.sv
// Debounced multi-button router: synchronizes and debounces raw buttons, then emits
// press / long-press / auto-repeat pulses on the output lane selected by the mode latched at press time.
module button_router_n #(
  parameter int N_BTN         = 3,
  parameter int N_MODE        = 2,
  parameter int DB_CYCLES     = 100000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  localparam int MW           = (N_MODE > 1) ? $clog2(N_MODE) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MW-1:0]             mode,
  input  logic [N_BTN-1:0]          btn_in,
  output logic [N_BTN-1:0]          o_held,
  output logic [N_MODE*N_BTN-1:0]   o_press,
  output logic [N_MODE*N_BTN-1:0]   o_long
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int LW  = $clog2(LONG_CYCLES);
  localparam int RW  = $clog2(REPEAT_CYCLES);

  localparam logic [DBW-1:0] DB_TERM   = DBW'(DB_CYCLES - 1);
  localparam logic [LW-1:0]  LONG_TERM = LW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0]  REP_TERM  = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  for (genvar b = 0; b < N_BTN; b++) begin : g_ch
    logic              r_sync1;
    logic              r_sync2;
    logic              r_held;
    logic [DBW-1:0]    r_db_cnt;
    logic [LW-1:0]     r_hold_cnt;
    logic [LW-1:0]     w_hold_cnt_nxt;
    logic [RW-1:0]     r_rep_cnt;
    logic [RW-1:0]     w_rep_cnt_nxt;
    logic [MW-1:0]     r_mode;
    logic [MW-1:0]     w_mode_nxt;
    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_press_ev;
    logic              w_long_ev;
    logic [N_MODE-1:0] w_press_vec;
    logic [N_MODE-1:0] w_long_vec;
    logic [N_MODE-1:0] r_press;
    logic [N_MODE-1:0] r_long;

    // Two-flop synchronizer feeding a stable-run debouncer; any agreeing sample restarts the run.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_sync1  <= 1'b0;
        r_sync2  <= 1'b0;
        r_held   <= 1'b0;
        r_db_cnt <= '0;
      end else begin
        // NOTE: non-blocking assignments let every flop sample the pre-edge value of its source.
        r_sync1 <= btn_in[b];
        r_sync2 <= r_sync1;
        if (r_sync2 != r_held) begin
          if (r_db_cnt == DB_TERM) begin
            r_held   <= ~r_held;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + DBW'(1);
          end
        end else begin
          r_db_cnt <= '0;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state    <= S_IDLE;
        r_hold_cnt <= '0;
        r_rep_cnt  <= '0;
        r_mode     <= '0;
        r_press    <= '0;
        r_long     <= '0;
      end else begin
        r_state    <= w_state_nxt;
        r_hold_cnt <= w_hold_cnt_nxt;
        r_rep_cnt  <= w_rep_cnt_nxt;
        r_mode     <= w_mode_nxt;
        r_press    <= w_press_vec;
        r_long     <= w_long_vec;
      end
    end

    always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      w_state_nxt    = r_state;
      w_hold_cnt_nxt = r_hold_cnt;
      w_rep_cnt_nxt  = r_rep_cnt;
      w_mode_nxt     = r_mode;
      w_press_ev     = 1'b0;
      w_long_ev      = 1'b0;
      unique case (r_state)
        S_IDLE: begin
          w_hold_cnt_nxt = '0;
          w_rep_cnt_nxt  = '0;
          if (r_held) begin
            w_state_nxt = S_HOLD;
            w_mode_nxt  = mode;
            w_press_ev  = 1'b1;
          end
        end
        S_HOLD: begin
          if (!r_held) begin
            w_state_nxt    = S_IDLE;
            w_hold_cnt_nxt = '0;
            w_rep_cnt_nxt  = '0;
          end else if (r_hold_cnt == LONG_TERM) begin
            w_state_nxt    = S_REPEAT;
            w_hold_cnt_nxt = '0;
            w_rep_cnt_nxt  = '0;
            w_long_ev      = 1'b1;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + LW'(1);
          end
        end
        S_REPEAT: begin
          if (!r_held) begin
            w_state_nxt    = S_IDLE;
            w_hold_cnt_nxt = '0;
            w_rep_cnt_nxt  = '0;
          end else if (r_rep_cnt == REP_TERM) begin
            w_rep_cnt_nxt = '0;
            w_press_ev    = 1'b1;
          end else begin
            w_rep_cnt_nxt = r_rep_cnt + RW'(1);
          end
        end
        default: begin
          w_state_nxt    = S_IDLE;
          w_hold_cnt_nxt = '0;
          w_rep_cnt_nxt  = '0;
        end
      endcase

      // Lane select uses the latched mode; an out-of-range mode matches no lane.
      w_press_vec = '0;
      w_long_vec  = '0;
      for (int m = 0; m < N_MODE; m++) begin
        w_press_vec[m] = w_press_ev && (w_mode_nxt == MW'(m));
        w_long_vec[m]  = w_long_ev  && (w_mode_nxt == MW'(m));
      end
    end

    assign o_held[b] = r_held;
    for (genvar m = 0; m < N_MODE; m++) begin : g_lane
      assign o_press[m*N_BTN+b] = r_press[m];
      assign o_long[m*N_BTN+b]  = r_long[m];
    end
  end

endmodule

// File: tb/tb_button_router_n.sv
// Self-checking bench for button_router_n: directed scenarios plus random stimulus,
// compared cycle by cycle against a press-age based reference model.
module tb_button_router_n;

  localparam int NB   = 3;
  localparam int NM   = 3;
  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        mode;
  logic [NB-1:0]     btn_in;
  logic [NB-1:0]     o_held;
  logic [NM*NB-1:0]  o_press;
  logic [NM*NB-1:0]  o_long;

  int n_checks = 0;
  int n_fail   = 0;

  button_router_n #(
    .N_BTN(NB), .N_MODE(NM), .DB_CYCLES(DB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .btn_in(btn_in),
    .o_held(o_held), .o_press(o_press), .o_long(o_long)
  );

  always #5 clk = ~clk;

  // Reference model: a delay line, a stable-run debouncer, and pulses derived from
  // the age (in cycles) of the current press, measured from the first cycle o_held reads 1.
  logic [NB-1:0]    m_s1, m_s2, m_held, m_was;
  int               m_run [NB];
  int               m_age [NB];
  int               m_lm  [NB];
  logic [NB-1:0]    exp_held;
  logic [NM*NB-1:0] exp_press, exp_long;

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_held = '0; m_was = '0;
    exp_held = '0; exp_press = '0; exp_long = '0;
    for (int b = 0; b < NB; b++) begin
      m_run[b] = 0; m_age[b] = 0; m_lm[b] = 0;
    end
  endtask

  task automatic model_step();
    exp_press = '0;
    exp_long  = '0;
    for (int b = 0; b < NB; b++) begin
      if (m_held[b]) begin
        if (!m_was[b]) begin
          m_age[b] = 0;
          m_lm[b]  = int'(mode);
        end else begin
          m_age[b]++;
        end
        if (m_lm[b] < NM) begin
          if (m_age[b] == 0 || (m_age[b] > LONG && (m_age[b] - LONG) % REP == 0))
            exp_press[m_lm[b]*NB + b] = 1'b1;
          if (m_age[b] == LONG)
            exp_long[m_lm[b]*NB + b] = 1'b1;
        end
      end
      m_was[b] = m_held[b];
      if (m_s2[b] != m_held[b]) begin
        m_run[b]++;
        if (m_run[b] == DB) begin
          m_held[b] = ~m_held[b];
          m_run[b]  = 0;
        end
      end else begin
        m_run[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = btn_in[b];
    end
    exp_held = m_held;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_clear();
      else      model_step();
    end
  end

  task automatic test_reset();
    rst = 1'b0; btn_in = '0; mode = '0;
    #1;
    n_checks++;
    if ({o_held, o_press, o_long} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial got=%h want=0", {o_held, o_press, o_long});
    end
    btn_in = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_held, o_press, o_long} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%h want=0", i, {o_held, o_press, o_long});
      end
    end
    btn_in = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_glitch();
    int n_act = 0;
    @(negedge clk);
    mode = 2'd0; btn_in = 3'b001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_held, o_press, o_long} !== {exp_held, exp_press, exp_long}) begin
        n_fail++;
        $display("FAIL glitch t=%0t got held=%b press=%b long=%b want held=%b press=%b long=%b",
                 $time, o_held, o_press, o_long, exp_held, exp_press, exp_long);
      end
      if (o_held != '0 || o_press != '0 || o_long != '0) n_act++;
      if (i == 2) btn_in = '0;
    end
    n_checks++;
    if (n_act !== 0) begin
      n_fail++;
      $display("FAIL glitch_activity got=%0d active cycles want=0", n_act);
    end
  endtask

  task automatic test_short_press();
    int first_held = -1;
    int n_p5 = 0;
    int n_other = 0;
    @(negedge clk);
    mode = 2'd1; btn_in = 3'b100;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_held, o_press, o_long} !== {exp_held, exp_press, exp_long}) begin
        n_fail++;
        $display("FAIL short t=%0t got held=%b press=%b long=%b want held=%b press=%b long=%b",
                 $time, o_held, o_press, o_long, exp_held, exp_press, exp_long);
      end
      if (o_held[2] === 1'b1 && first_held < 0) first_held = i;
      if (o_press[5] === 1'b1) n_p5++;
      if ((o_press & ~(9'b1 << 5)) != '0 || o_long != '0) n_other++;
      if (i == 9) btn_in = '0;
    end
    n_checks++;
    if (first_held !== 5) begin
      n_fail++;
      $display("FAIL short_held_latency got=%0d want=5", first_held);
    end
    n_checks++;
    if (n_p5 !== 1 || n_other !== 0) begin
      n_fail++;
      $display("FAIL short_pulses got press5=%0d other=%0d want 1 and 0", n_p5, n_other);
    end
  endtask

  task automatic test_long_repeat();
    int n_p = 0;
    int n_l = 0;
    int first_p = -1;
    int first_l = -1;
    @(negedge clk);
    mode = 2'd0; btn_in = 3'b010;
    for (int i = 0; i < 76; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_held, o_press, o_long} !== {exp_held, exp_press, exp_long}) begin
        n_fail++;
        $display("FAIL long t=%0t got held=%b press=%b long=%b want held=%b press=%b long=%b",
                 $time, o_held, o_press, o_long, exp_held, exp_press, exp_long);
      end
      if (o_press[1] === 1'b1) begin n_p++; if (first_p < 0) first_p = i; end
      if (o_long[1] === 1'b1)  begin n_l++; if (first_l < 0) first_l = i; end
      if (i == 59) btn_in = '0;
    end
    n_checks++;
    if (n_p !== 5 || n_l !== 1) begin
      n_fail++;
      $display("FAIL long_counts got press=%0d long=%0d want 5 and 1", n_p, n_l);
    end
    n_checks++;
    if (first_l - first_p !== 20) begin
      n_fail++;
      $display("FAIL long_delay got=%0d want=20", first_l - first_p);
    end
  endtask

  task automatic test_mode_latch();
    int n_p6 = 0;
    int n_l6 = 0;
    int n_other = 0;
    @(negedge clk);
    mode = 2'd2; btn_in = 3'b001;
    for (int i = 0; i < 56; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_held, o_press, o_long} !== {exp_held, exp_press, exp_long}) begin
        n_fail++;
        $display("FAIL latch t=%0t got held=%b press=%b long=%b want held=%b press=%b long=%b",
                 $time, o_held, o_press, o_long, exp_held, exp_press, exp_long);
      end
      if (o_press[6] === 1'b1) n_p6++;
      if (o_long[6] === 1'b1)  n_l6++;
      if ((o_press & ~(9'b1 << 6)) != '0 || (o_long & ~(9'b1 << 6)) != '0) n_other++;
      if (i == 10) mode = 2'd0;
      if (i == 39) btn_in = '0;
    end
    n_checks++;
    if (n_p6 !== 3 || n_l6 !== 1 || n_other !== 0) begin
      n_fail++;
      $display("FAIL latch_counts got p6=%0d l6=%0d other=%0d want 3 1 0", n_p6, n_l6, n_other);
    end
  endtask

  task automatic test_out_of_range();
    int n_held = 0;
    int n_pulse = 0;
    @(negedge clk);
    mode = 2'd3; btn_in = 3'b001;
    for (int i = 0; i < 56; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_held, o_press, o_long} !== {exp_held, exp_press, exp_long}) begin
        n_fail++;
        $display("FAIL oor t=%0t got held=%b press=%b long=%b want held=%b press=%b long=%b",
                 $time, o_held, o_press, o_long, exp_held, exp_press, exp_long);
      end
      if (o_held[0] === 1'b1) n_held++;
      if (o_press != '0 || o_long != '0) n_pulse++;
      if (i == 39) btn_in = '0;
    end
    n_checks++;
    if (n_held == 0 || n_pulse !== 0) begin
      n_fail++;
      $display("FAIL oor_counts got held_cycles=%0d pulse_cycles=%0d want >0 and 0", n_held, n_pulse);
    end
    mode = 2'd0;
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    mode = 2'd1; btn_in = 3'b111;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_held, o_press, o_long} !== {exp_held, exp_press, exp_long}) begin
        n_fail++;
        $display("FAIL simul t=%0t got held=%b press=%b long=%b want held=%b press=%b long=%b",
                 $time, o_held, o_press, o_long, exp_held, exp_press, exp_long);
      end
      if (i == 6) begin
        n_checks++;
        if (o_press !== 9'b000_111_000) begin
          n_fail++;
          $display("FAIL simul_lanes got=%b want=000111000", o_press);
        end
      end
      if (i == 9) btn_in = '0;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mode = 2'd0; btn_in = 3'b010;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_held, o_press, o_long} !== {exp_held, exp_press, exp_long}) begin
        n_fail++;
        $display("FAIL rstmid_pre t=%0t got held=%b press=%b long=%b want held=%b press=%b long=%b",
                 $time, o_held, o_press, o_long, exp_held, exp_press, exp_long);
      end
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({o_held, o_press, o_long} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async got=%h want=0", {o_held, o_press, o_long});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_held, o_press, o_long} !== {exp_held, exp_press, exp_long}) begin
        n_fail++;
        $display("FAIL rstmid_post t=%0t got held=%b press=%b long=%b want held=%b press=%b long=%b",
                 $time, o_held, o_press, o_long, exp_held, exp_press, exp_long);
      end
      n_checks++;
      if (o_held[1] !== (i >= 6) || o_press[1] !== (i == 7)) begin
        n_fail++;
        $display("FAIL rstmid_repress cyc=%0d got held1=%b press1=%b want %b %b",
                 i, o_held[1], o_press[1], (i >= 6), (i == 7));
      end
    end
    btn_in = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_held, o_press, o_long} !== {exp_held, exp_press, exp_long}) begin
        n_fail++;
        $display("FAIL rstmid_release t=%0t got held=%b press=%b long=%b want held=%b press=%b long=%b",
                 $time, o_held, o_press, o_long, exp_held, exp_press, exp_long);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_held, o_press, o_long} !== {exp_held, exp_press, exp_long}) begin
        n_fail++;
        $display("FAIL random t=%0t got held=%b press=%b long=%b want held=%b press=%b long=%b",
                 $time, o_held, o_press, o_long, exp_held, exp_press, exp_long);
      end
      for (int b = 0; b < NB; b++)
        if ($urandom_range(23, 0) == 0) btn_in[b] = ~btn_in[b];
      if ($urandom_range(7, 0) == 0) mode = 2'($urandom_range(3, 0));
    end
    btn_in = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_held, o_press, o_long} !== {exp_held, exp_press, exp_long}) begin
        n_fail++;
        $display("FAIL random_tail t=%0t got held=%b press=%b long=%b want held=%b press=%b long=%b",
                 $time, o_held, o_press, o_long, exp_held, exp_press, exp_long);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_short_press();
    test_long_repeat();
    test_mode_latch();
    test_out_of_range();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
